// File: rtl/stream_mux.sv
// Registered N:1 valid/ready stream multiplexer.
// Addressed or round-robin channel selection, one-entry output register.
module stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int AW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [AW-1:0]             address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AW-1:0]             out_channel
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    chan_q, chan_d;
  logic [AW-1:0]    ptr_q, ptr_d;

  logic          can_accept;
  logic          sel_ok;
  logic [AW-1:0] sel;
  logic [AW-1:0] idx;
  logic          xfer_in;
  logic          xfer_out;

  // Scan from the farthest offset down so the nearest valid channel wins.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    idx    = '0;
    if (!mode) begin
      sel    = address;
      sel_ok = 1'b1;
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        idx = ptr_q + AW'(k);
        if (in_valid[idx]) begin
          sel    = idx;
          sel_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    can_accept = !valid_q || out_ready;
    in_ready   = '0;
    if (sel_ok && can_accept && !reset) begin
      in_ready[sel] = 1'b1;
    end
    xfer_in  = sel_ok && in_valid[sel] && in_ready[sel];
    xfer_out = valid_q && out_ready;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer_in) begin
      valid_d = 1'b1;
      data_d  = in_data[int'(sel)*WIDTH +: WIDTH];
      chan_d  = sel;
      if (mode) begin
        ptr_d = sel + AW'(1);
      end
    end else if (xfer_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_channel = chan_q;

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised, registered N:1 stream multiplexer with valid/ready handshakes on every channel and a one-entry output register. It selects either the channel given by an address input or, in round-robin mode, the next valid channel after the last one granted. It is the sequential, W-bit, N-channel successor of the team's 4:1 single-bit address-select multiplexer, for use in front of a shared downstream consumer.

## Interface
- WIDTH, 8: data bits per channel (≥1).
- CHANNELS, 4: number of input channels; power of two, ≥2. Derived localparam AW = log2(CHANNELS).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset is synchronous and active-high; one clock, synchronous active-high reset.
- mode  in  1  0 = addressed select, 1 = round-robin.
- address  in  AW  selected channel in addressed mode; ignored in round-robin mode.
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; at most one bit high.
- out_data  out  WIDTH  registered output word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts the word.
- out_channel  out  AW  source channel of the word in out_data.

## Operation
- State: output register {out_valid, out_data, out_channel}; round-robin pointer ptr (AW bits).
- can_accept = !out_valid || out_ready.
- Selected channel sel:
  - mode 0: sel = address.
  - mode 1: sel = first i with in_valid[i] high, scanning ptr, ptr+1, …, wrapping modulo CHANNELS. If no bit is valid, there is no sel.
- in_ready[sel] = can_accept && !reset. All other in_ready bits are 0. In mode 1 with no valid channel, all bits are 0.
- Transfer in = in_valid[sel] && in_ready[sel]. On transfer:
  - out_data <= in_data[sel];
  - out_channel <= sel;
  - out_valid <= 1.
- Transfer out = out_valid && out_ready. If transfer out occurs with no transfer in, out_valid <= 0. out_data and out_channel hold their values.
- Simultaneous transfer out and transfer in: the register is replaced by the new word and out_valid stays 1 (full throughput).
- ptr:
  - In mode 1, on transfer in, ptr <= (sel+1) mod CHANNELS.
  - Otherwise ptr holds. Mode 0 never modifies ptr.
- Mode or address changes take effect on the same cycle's selection. A word already in the register is unaffected.
- Reset (including mid-stream) clears out_valid to 0, out_data to 0, out_channel to 0 and ptr to 0. Any held word is discarded.

## Timing
- Latency: a word accepted at edge k appears with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one word per cycle while out_ready=1 and the selected channel is valid.
- Outputs after reset: out_valid=0, out_data=0, out_channel=0, in_ready=0 during any cycle with reset=1.
- out_data and out_channel are stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready, mode, address, in_valid and ptr. It never depends on in_data.
- out_valid must not depend on out_ready within a cycle.
- There is no combinational path from any input to out_data, out_valid or out_channel.
- Backpressure: with out_valid=1 and out_ready=0, in_ready is all-zero and no input word is lost.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,2,…,CHANNELS-1,0 with no repeats.

## Test plan
- **Reset.** Assert reset 2 cycles with all in_valid=1 and out_ready=1. Required: out_valid=0, out_data=0, out_channel=0, in_ready=0000 throughout. The first word appears one cycle after reset falls.
- **Addressed select.** WIDTH=8, CHANNELS=4, mode=0, address=2, in_data ch0..3 = 0x11,0x22,0x33,0x44, all valid, out_ready=1. Required: in_ready=0100; next cycle out_data=0x33, out_channel=2. Changing address to 1 gives out_data=0x22 one cycle later.
- **Backpressure.** mode=0, address=0, out_ready=0 after the first word 0xA5 is captured. Required: out_data holds 0xA5, in_ready=0000 and in_data changes are ignored. On out_ready=1, the next word is captured in the same cycle that 0xA5 drains.
- **Round-robin wrap.** mode=1, all valid, out_ready=1, 8 cycles. Required: out_channel sequence 0,1,2,3,0,1,2,3 and ptr wraps 3→0.
- **Round-robin skip.** mode=1, in_valid=1010, ptr=0. Required: grants go 1,3,1,3. With in_valid=0000, out_valid drops after the drain and ptr holds.
- **Reset mid-operation.** Assert reset while out_valid=1 and out_ready=0 holding 0x5C, with ptr=2. Required: next cycle out_valid=0, out_data=0, and ptr=0, so the first round-robin grant after reset is the lowest valid channel from 0.
